// File: rtl/uart_pkg.sv
// Types and constants shared by the UART TX engine and the RX path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Frame length in bit periods: start bit, data bits, stop bits.
  function automatic int unsigned uart_frame_len(input int unsigned data_bits,
                                                 input int unsigned stop_bits);
    return 1 + data_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO. Push is registered; the head entry is always visible on pop_data.
// Pushes while full and pops while empty are dropped.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW + 1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1-style UART transmitter: bytes queue in a FIFO and are shifted out LSB first on baud_tick.
// Start bit begins on the first tick after a push; in_ready drops only while the FIFO is full.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          tx_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_idle
);

  localparam int BCW = $clog2(DATA_BITS);

  tx_state_e            state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic [BCW-1:0]       bit_cnt;
  logic                 stop_cnt;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 last_stop;

  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  // The FIFO head is consumed on the tick that launches a start bit.
  always_comb begin
    pop = 1'b0;
    if (baud_tick && !empty && (state == IDLE || (state == STOP && last_stop)))
      pop = 1'b1;
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= UART_IDLE_LVL;
      tx_en    <= 1'b0;
      tx_idle  <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      tx_idle <= empty && (state == IDLE);
      if (baud_tick) begin
        unique case (state)
          IDLE: begin
            if (!empty) begin
              shift <= head;
              tx    <= UART_START_LVL;
              tx_en <= 1'b1;
              state <= START;
            end
          end
          START: begin
            tx      <= shift[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt == BCW'(DATA_BITS - 1)) begin
              tx       <= UART_IDLE_LVL;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          STOP: begin
            if (!last_stop) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else if (!empty) begin
              // Next byte follows straight on, no idle bit between frames.
              shift <= head;
              tx    <= UART_START_LVL;
              state <= START;
            end else begin
              tx    <= UART_IDLE_LVL;
              tx_en <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench: stimulus queues expected tx bits, a tick-driven monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, tx_en, tx_idle;
  logic [3:0] fifo_level;
  logic [7:0] in_data2 = 8'h00;
  logic       in_valid2 = 1'b0;
  logic       in_ready2, tx2, tx_en2, tx_idle2;
  logic [3:0] fifo_level2;

  int n_cmp = 0;
  int n_bad = 0;
  bit tick_on = 1'b0;
  int tick_div = 0;
  bit q1[$];
  bit q2[$];
  bit prev1 = 1'b0;
  bit prev2 = 1'b0;

  uart_tx_engine #(.DATA_BITS(8), .FIFO_DEPTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .tx_en(tx_en), .fifo_level(fifo_level), .tx_idle(tx_idle));

  uart_tx_engine #(.DATA_BITS(8), .FIFO_DEPTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .tx(tx2), .tx_en(tx_en2), .fifo_level(fifo_level2), .tx_idle(tx_idle2));

  initial forever #5 clk = ~clk;

  // Free-running baud pulse every 16 clks while tick_on is set.
  initial forever begin
    @(posedge clk);
    #1;
    baud_tick = tick_on && (tick_div == 15);
    tick_div  = (tick_div + 1) % 16;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic sb_bit(input string nm, input logic act, input bit have, input bit exp);
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL %s: got %b with no bit expected", nm, act);
    end else if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Monitor: after every tick, a line with tx_en high carries exactly one frame bit.
  initial forever begin
    bit h;
    bit e;
    @(posedge clk);
    if (rst) begin
      prev1 = 1'b0;
      prev2 = 1'b0;
    end else if (baud_tick) begin
      @(negedge clk);
      if (tx_en) begin
        h = (q1.size() > 0);
        e = h ? q1.pop_front() : 1'b0;
        sb_bit("tx1 bit", tx, h, e);
      end else begin
        check("tx1 idle level", int'(tx), 1);
        if (prev1) check("tx1 frame end with bits pending", q1.size(), 0);
      end
      if (tx_en2) begin
        h = (q2.size() > 0);
        e = h ? q2.pop_front() : 1'b0;
        sb_bit("tx2 bit", tx2, h, e);
      end else begin
        check("tx2 idle level", int'(tx2), 1);
        if (prev2) check("tx2 frame end with bits pending", q2.size(), 0);
      end
      prev1 = tx_en;
      prev2 = tx_en2;
    end
  end

  // Bits in transmission order, first bit in the MSB of the n-bit vector.
  task automatic exp_vec1(input logic [15:0] v, input int n);
    logic [15:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) q1.push_back(t[i]);
  endtask

  task automatic exp_byte1(input logic [7:0] b);
    q1.push_back(1'b0);
    for (int i = 0; i < 8; i++) q1.push_back(b[i]);
    q1.push_back(1'b1);
  endtask

  task automatic push1(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !in_ready; i++) @(negedge clk);
    check("push1 ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      if (baud_tick) begin
        seen = 1'b1;
        break;
      end
    end
    check("baud tick seen", int'(seen), 1);
  endtask

  task automatic drain(input int max_clk);
    bit done = 1'b0;
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q2.size() == 0 && tx_idle && tx_idle2) begin
        done = 1'b1;
        break;
      end
    end
    check("drain to idle", int'(done), 1);
  endtask

  task automatic ticks_off();
    @(negedge clk);
    tick_on = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset tx", int'(tx), 1);
    check("reset tx_en", int'(tx_en), 0);
    check("reset fifo_level", int'(fifo_level), 0);
    check("reset in_ready", int'(in_ready), 1);
    check("reset tx_idle", int'(tx_idle), 1);
    check("reset tx2", int'(tx2), 1);
    rst = 1'b0;
    tick_on = 1'b1;
    repeat (4) @(negedge clk);

    // Single 0xA5 frame.
    exp_vec1(16'b0101001011, 10);
    push1(8'hA5);
    drain(600);
    check("A5 tx_en after frame", int'(tx_en), 0);
    check("A5 tx_idle after frame", int'(tx_idle), 1);
    check("A5 fifo_level after frame", int'(fifo_level), 0);

    // 0x55 and 0x0F back to back: 20 contiguous bits.
    exp_vec1(16'b0101010101, 10);
    exp_vec1(16'b0111100001, 10);
    push1(8'h55);
    push1(8'h0F);
    drain(1000);

    // Fill the FIFO with ticks held off; the ninth byte must be refused.
    ticks_off();
    for (int k = 0; k < 8; k++) exp_byte1(8'(k + 1));
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      in_data  = 8'(k + 1);
      in_valid = 1'b1;
      if (k == 7) check("fill level before 8th push", int'(fifo_level), 7);
      if (k == 8) check("fill in_ready before 9th push", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("full fifo_level", int'(fifo_level), 8);
    check("full in_ready", int'(in_ready), 0);
    check("full tx_en with ticks held", int'(tx_en), 0);
    tick_on = 1'b1;
    wait_tick();
    #1;
    check("first tick fifo_level", int'(fifo_level), 7);
    check("first tick in_ready", int'(in_ready), 1);
    drain(3000);

    // Push coinciding with the IDLE->START pop at level 3.
    ticks_off();
    exp_byte1(8'h11);
    exp_byte1(8'h22);
    exp_byte1(8'h33);
    exp_byte1(8'h44);
    push1(8'h11);
    push1(8'h22);
    push1(8'h33);
    @(negedge clk);
    check("level before push+pop", int'(fifo_level), 3);
    in_data   = 8'h44;
    in_valid  = 1'b1;
    baud_tick = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    baud_tick = 1'b0;
    #1;
    check("push+pop fifo_level", int'(fifo_level), 3);
    check("push+pop tx start", int'(tx), 0);
    check("push+pop tx_en", int'(tx_en), 1);
    tick_on = 1'b1;
    drain(2000);

    // Reset in the middle of data bit 4 with two bytes still queued.
    ticks_off();
    exp_byte1(8'hC3);
    exp_byte1(8'h3C);
    exp_byte1(8'h96);
    push1(8'hC3);
    push1(8'h3C);
    push1(8'h96);
    tick_on = 1'b1;
    repeat (6) wait_tick();
    repeat (8) @(negedge clk);
    check("pre-reset fifo_level", int'(fifo_level), 2);
    check("pre-reset tx bit4 of C3", int'(tx), 0);
    check("pre-reset tx_en", int'(tx_en), 1);
    q1.delete();
    rst = 1'b1;
    #1;
    check("mid-frame reset tx", int'(tx), 1);
    check("mid-frame reset tx_en", int'(tx_en), 0);
    check("mid-frame reset fifo_level", int'(fifo_level), 0);
    check("mid-frame reset in_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    check("post-reset tx_idle", int'(tx_idle), 1);
    check("post-reset tx", int'(tx), 1);

    // Two stop bits: 0x00 is nine low bit periods then two high.
    for (int i = 10; i >= 0; i--) q2.push_back(i < 2);
    @(negedge clk);
    check("dut2 in_ready", int'(in_ready2), 1);
    in_data2  = 8'h00;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    drain(600);
    check("dut2 tx_en after frame", int'(tx_en2), 0);
    check("dut2 tx_idle after frame", int'(tx_idle2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
